// File: rtl/input_buffer_80_pkg.sv
// -----------------------------------------------------------------------------
// input_buffer_80_pkg
// Shared constants for the 80-bit switch input buffer:
//   - flit type field width and encodings (low FTYPEWD bits of every flit)
//   - framing FSM state constants
//   - frame_step(): one step of the packet framing check
// -----------------------------------------------------------------------------
package input_buffer_80_pkg;

    // Flit type field: FLIT[FTYPEWD-1:0]
    localparam int unsigned FTYPEWD = 2;

    localparam logic [FTYPEWD-1:0] ENC_PAYL = 2'b00;
    localparam logic [FTYPEWD-1:0] ENC_SING = 2'b01;
    localparam logic [FTYPEWD-1:0] ENC_HEAD = 2'b10;
    localparam logic [FTYPEWD-1:0] ENC_TAIL = 2'b11;

    // Framing FSM states
    localparam logic [0:0] FSM_IDLE   = 1'b0;
    localparam logic [0:0] FSM_IN_PKT = 1'b1;

    typedef struct packed {
        logic       err;
        logic [0:0] state;
    } frame_step_t;

    // Next framing state plus error indication for one accepted flit.
    // An illegal flit raises err but leaves the state where it was.
    function automatic frame_step_t frame_step(input logic [0:0]         state,
                                               input logic [FTYPEWD-1:0] ftype);
        frame_step_t r;
        r.err   = 1'b0;
        r.state = state;
        if (state == FSM_IDLE) begin
            if (ftype == ENC_HEAD) begin
                r.state = FSM_IN_PKT;
            end else if (ftype != ENC_SING) begin
                r.err = 1'b1;
            end
        end else begin
            if (ftype == ENC_TAIL) begin
                r.state = FSM_IDLE;
            end else if (ftype != ENC_PAYL) begin
                r.err = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/input_buffer_80_framing.sv
// -----------------------------------------------------------------------------
// framing_checker_80
// Monitor-only packet framing checker for one input port. Tracks whether a
// packet is open (HEAD seen, TAIL not yet) and raises a sticky proto_err on
// any flit type that is illegal in the current state. Never alters data.
// Ports:
//   clk, rst      switch clock, synchronous active-high reset
//   i_push        a flit is being stored this cycle
//   i_ftype       type field of that flit
//   o_proto_err   sticky framing error flag
// -----------------------------------------------------------------------------
module framing_checker_80
    import input_buffer_80_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_push,
    input  logic [FTYPEWD-1:0] i_ftype,
    output logic               o_proto_err
);

    logic [0:0]  r_state;
    logic        r_err;
    frame_step_t w_step;

    always_comb begin
        w_step = frame_step(r_state, i_ftype);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FSM_IDLE;
            r_err   <= 1'b0;
        end else if (i_push) begin
            r_state <= w_step.state;
            if (w_step.err) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_proto_err = r_err;

endmodule

// File: rtl/input_buffer_80.sv
// -----------------------------------------------------------------------------
// input_buffer_80
// Per-input-port flit FIFO for the 80-bit switch. Stores flits from the
// upstream link, broadcasts the head flit to all output allocators, and
// retires it when no allocator signals not-accept.
// Ports:
//   clk, rst      switch clock, synchronous active-high reset
//   FLIT_in       flit from upstream link
//   VALID_in      FLIT_in valid
//   busy_out      registered stall toward upstream link
//   FLIT_out      head flit (combinational read of mem[rd_ptr])
//   VALID_out     FIFO non-empty
//   nack_in       per-allocator not-accept for this input
//   proto_err     sticky framing error
//   overflow_err  sticky push-while-full (flit dropped)
// -----------------------------------------------------------------------------
module input_buffer_80
    import input_buffer_80_pkg::*;
#(
    parameter int unsigned FLIT_W = 80,
    parameter int unsigned DEPTH  = 6,
    parameter int unsigned SLACK  = 2,
    parameter int unsigned N_OUT  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLIT_W-1:0] FLIT_in,
    input  logic              VALID_in,
    output logic              busy_out,
    output logic [FLIT_W-1:0] FLIT_out,
    output logic              VALID_out,
    input  logic [N_OUT-1:0]  nack_in,
    output logic              proto_err,
    output logic              overflow_err
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    // busy must go up while SLACK entries are still free: the registered
    // busy_out and the link round trip let that many more flits arrive.
    localparam logic [CNT_W-1:0] BUSY_THR = CNT_W'(DEPTH - SLACK);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [FLIT_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_busy;
    logic              r_ovf;

    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic [CNT_W-1:0]  w_count_next;

    assign VALID_out = (r_count != '0);
    assign FLIT_out  = r_mem[r_rd_ptr];

    // Silence on every nack line means the one interested allocator took it.
    assign w_pop  = VALID_out & ~|nack_in;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_push = VALID_in & ((r_count < CNT_FULL) | w_pop);
    assign w_drop = VALID_in & ~w_push;

    assign w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= FLIT_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_busy   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
            end
            r_count <= w_count_next;
            r_busy  <= (w_count_next >= BUSY_THR);
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign busy_out     = r_busy;
    assign overflow_err = r_ovf;

    // Dropped flits never reach the checker, so they do not advance framing.
    framing_checker_80 u_framing (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_ftype     (FLIT_in[FTYPEWD-1:0]),
        .o_proto_err (proto_err)
    );

endmodule

// File: tb/tb_input_buffer_80.sv
// -----------------------------------------------------------------------------
// tb_input_buffer_80
// Self-checking bench for input_buffer_80 (DEPTH=6, SLACK=2). Inputs change
// 1 time unit after the rising edge; outputs are sampled on the falling edge.
// The scoreboard queue holds the flits the FIFO should contain; accepted
// pushes are appended, and each pop is compared against the queue head.
// -----------------------------------------------------------------------------
module tb_input_buffer_80;
    import input_buffer_80_pkg::*;

    localparam int unsigned FW   = 80;
    localparam int unsigned DEP  = 6;
    localparam int unsigned SLK  = 2;
    localparam int unsigned NOUT = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [FW-1:0]   FLIT_in;
    logic            VALID_in;
    logic            busy_out;
    logic [FW-1:0]   FLIT_out;
    logic            VALID_out;
    logic [NOUT-1:0] nack_in;
    logic            proto_err;
    logic            overflow_err;

    always #5 clk = ~clk;

    input_buffer_80 #(
        .FLIT_W (FW),
        .DEPTH  (DEP),
        .SLACK  (SLK),
        .N_OUT  (NOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .FLIT_in      (FLIT_in),
        .VALID_in     (VALID_in),
        .busy_out     (busy_out),
        .FLIT_out     (FLIT_out),
        .VALID_out    (VALID_out),
        .nack_in      (nack_in),
        .proto_err    (proto_err),
        .overflow_err (overflow_err)
    );

    // Reference model state
    logic [FW-1:0] sb [$];
    logic          busy_m;
    logic          ovf_m;
    logic          proto_m;
    logic          inpkt_m;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [FW-1:0] mk(input int unsigned id, input logic [1:0] t);
        return {78'(id), t};
    endfunction

    task automatic model_reset();
        sb.delete();
        busy_m  = 1'b0;
        ovf_m   = 1'b0;
        proto_m = 1'b0;
        inpkt_m = 1'b0;
    endtask

    // Apply inputs just after a rising edge, then move to the sample point.
    task automatic drive(input logic [FW-1:0] f, input logic v, input logic [NOUT-1:0] n);
        FLIT_in  = f;
        VALID_in = v;
        nack_in  = n;
        @(negedge clk);
    endtask

    // Advance the model across the coming rising edge (pops already removed).
    task automatic commit();
        logic [1:0] t;
        if (rst) begin
            model_reset();
        end else if (VALID_in) begin
            if (sb.size() < 6) begin
                sb.push_back(FLIT_in);
                t = FLIT_in[1:0];
                if (!inpkt_m) begin
                    if (t == ENC_HEAD) inpkt_m = 1'b1;
                    else if (t != ENC_SING) proto_m = 1'b1;
                end else begin
                    if (t == ENC_TAIL) inpkt_m = 1'b0;
                    else if (t != ENC_PAYL) proto_m = 1'b1;
                end
            end else begin
                ovf_m = 1'b1;
            end
        end
        busy_m = (sb.size() >= 4);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; VALID_in = 1'b0; nack_in = '0; FLIT_in = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        model_reset();
        @(negedge clk);
        n_checks++; if (VALID_out !== 1'b0)    begin n_fail++; $display("FAIL rst_valid got %b exp 0", VALID_out); end
        n_checks++; if (busy_out !== 1'b0)     begin n_fail++; $display("FAIL rst_busy got %b exp 0", busy_out); end
        n_checks++; if (proto_err !== 1'b0)    begin n_fail++; $display("FAIL rst_proto got %b exp 0", proto_err); end
        n_checks++; if (overflow_err !== 1'b0) begin n_fail++; $display("FAIL rst_ovf got %b exp 0", overflow_err); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [FW-1:0] e;
        for (int c = 0; c < 3; c++) begin
            drive(mk(0, ENC_SING), (c == 0), 4'b0000);
            n_checks++; if (VALID_out !== (c == 1)) begin n_fail++; $display("FAIL single_valid c%0d got %b exp %b", c, VALID_out, (c == 1)); end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                n_checks++; if (FLIT_out !== e) begin n_fail++; $display("FAIL single_flit got %h exp %h", FLIT_out, e); end
            end
            n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL single_proto got %b exp 0", proto_err); end
            commit();
        end
    endtask

    task automatic test_hold_packet();
        logic [1:0]      ft [5];
        logic [NOUT-1:0] n;
        logic            v;
        logic [FW-1:0]   f;
        logic [FW-1:0]   e;
        ft[0] = ENC_HEAD; ft[1] = ENC_PAYL; ft[2] = ENC_PAYL; ft[3] = ENC_PAYL; ft[4] = ENC_TAIL;
        for (int c = 0; c < 10; c++) begin
            v = (c < 5);
            f = v ? mk(100 + c, ft[c]) : '0;
            n = (c == 1 || c == 2) ? 4'b0001 : 4'b0000;
            drive(f, v, n);
            n_checks++; if (VALID_out !== (sb.size() != 0)) begin n_fail++; $display("FAIL pkt_valid c%0d got %b exp %b", c, VALID_out, (sb.size() != 0)); end
            n_checks++; if (busy_out !== busy_m) begin n_fail++; $display("FAIL pkt_busy c%0d got %b exp %b", c, busy_out, busy_m); end
            if (sb.size() != 0) begin
                n_checks++; if (FLIT_out !== sb[0]) begin n_fail++; $display("FAIL pkt_head c%0d got %h exp %h", c, FLIT_out, sb[0]); end
                if (n == '0) e = sb.pop_front();
            end
            commit();
        end
        n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL pkt_proto got %b exp 0", proto_err); end
    endtask

    // Upstream stops one cycle after it sees busy_out.
    task automatic test_fill_busy();
        logic bprev;
        logic v;
        bprev = 1'b0;
        for (int c = 0; c < 8; c++) begin
            v = !bprev;
            drive(mk(200 + c, ENC_SING), v, 4'b1111);
            n_checks++; if (VALID_out !== (sb.size() != 0)) begin n_fail++; $display("FAIL fill_valid c%0d got %b exp %b", c, VALID_out, (sb.size() != 0)); end
            n_checks++; if (busy_out !== busy_m) begin n_fail++; $display("FAIL fill_busy c%0d got %b exp %b", c, busy_out, busy_m); end
            if (sb.size() != 0) begin
                n_checks++; if (FLIT_out !== sb[0]) begin n_fail++; $display("FAIL fill_head c%0d got %h exp %h", c, FLIT_out, sb[0]); end
            end
            n_checks++; if (overflow_err !== 1'b0) begin n_fail++; $display("FAIL fill_ovf c%0d got %b exp 0", c, overflow_err); end
            bprev = busy_out;
            commit();
        end
    endtask

    // From 5 entries: fill to 6, push+pop while full, overflow push, drain.
    task automatic test_full_overflow();
        logic [11:0]     vbits;
        logic [11:0]     nfull;
        logic [NOUT-1:0] n;
        logic [FW-1:0]   e;
        vbits = 12'b000000001011;
        nfull = 12'b000000001101;
        for (int c = 0; c < 12; c++) begin
            n = nfull[c] ? 4'b1111 : 4'b0000;
            drive(mk(300 + c, ENC_SING), vbits[c], n);
            n_checks++; if (VALID_out !== (sb.size() != 0)) begin n_fail++; $display("FAIL full_valid c%0d got %b exp %b", c, VALID_out, (sb.size() != 0)); end
            n_checks++; if (busy_out !== busy_m) begin n_fail++; $display("FAIL full_busy c%0d got %b exp %b", c, busy_out, busy_m); end
            n_checks++; if (overflow_err !== ovf_m) begin n_fail++; $display("FAIL full_ovf c%0d got %b exp %b", c, overflow_err, ovf_m); end
            if (sb.size() != 0) begin
                n_checks++; if (FLIT_out !== sb[0]) begin n_fail++; $display("FAIL full_head c%0d got %h exp %h", c, FLIT_out, sb[0]); end
                if (n == '0) e = sb.pop_front();
            end
            commit();
        end
    endtask

    task automatic test_framing();
        logic [1:0]    ft [4];
        logic          v;
        logic [FW-1:0] e;
        ft[0] = ENC_PAYL; ft[1] = ENC_HEAD; ft[2] = ENC_HEAD; ft[3] = ENC_TAIL;
        for (int c = 0; c < 8; c++) begin
            v = (c < 4);
            drive(v ? mk(400 + c, ft[c]) : '0, v, 4'b0000);
            n_checks++; if (VALID_out !== (sb.size() != 0)) begin n_fail++; $display("FAIL frm_valid c%0d got %b exp %b", c, VALID_out, (sb.size() != 0)); end
            n_checks++; if (proto_err !== proto_m) begin n_fail++; $display("FAIL frm_proto c%0d got %b exp %b", c, proto_err, proto_m); end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                n_checks++; if (FLIT_out !== e) begin n_fail++; $display("FAIL frm_flit c%0d got %h exp %h", c, FLIT_out, e); end
            end
            commit();
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0]    ft [3];
        logic [FW-1:0] e;
        ft[0] = ENC_TAIL; ft[1] = ENC_HEAD; ft[2] = ENC_PAYL;
        for (int c = 0; c < 3; c++) begin
            drive(mk(500 + c, ft[c]), 1'b1, 4'b1111);
            commit();
        end
        drive('0, 1'b0, 4'b1111);
        n_checks++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL mid_proto_pre got %b exp 1", proto_err); end
        n_checks++; if (VALID_out !== 1'b1) begin n_fail++; $display("FAIL mid_valid_pre got %b exp 1", VALID_out); end
        rst = 1'b1;
        commit();
        drive(mk(510, ENC_PAYL), 1'b1, 4'b1111);
        commit();
        rst = 1'b0;
        drive('0, 1'b0, 4'b0000);
        n_checks++; if (VALID_out !== 1'b0) begin n_fail++; $display("FAIL mid_valid got %b exp 0", VALID_out); end
        n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL mid_proto got %b exp 0", proto_err); end
        n_checks++; if (busy_out !== 1'b0)  begin n_fail++; $display("FAIL mid_busy got %b exp 0", busy_out); end
        commit();
        // A SING right after reset is legal only if framing returned to IDLE.
        for (int c = 0; c < 3; c++) begin
            drive(mk(520, ENC_SING), (c == 0), 4'b0000);
            n_checks++; if (VALID_out !== (sb.size() != 0)) begin n_fail++; $display("FAIL post_valid c%0d got %b exp %b", c, VALID_out, (sb.size() != 0)); end
            n_checks++; if (proto_err !== proto_m) begin n_fail++; $display("FAIL post_proto c%0d got %b exp %b", c, proto_err, proto_m); end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                n_checks++; if (FLIT_out !== e) begin n_fail++; $display("FAIL post_flit got %h exp %h", FLIT_out, e); end
            end
            commit();
        end
    endtask

    initial begin
        rst = 1'b1; VALID_in = 1'b0; nack_in = '0; FLIT_in = '0;
        model_reset();
        test_reset();
        test_single();
        test_hold_packet();
        test_fill_busy();
        test_full_overflow();
        test_reset();
        test_framing();
        test_reset();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
